// File: rtl/uart_tx_sched_if.sv
// Request/grant and uart_tx load bundle shared by the scheduler and its clients.
// master: scheduler side; slave: requesters plus the uart_tx load port.
interface uart_tx_sched_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_ready;
  logic [7:0]         tx_data;
  logic [ID_W-1:0]    grant_id;
  logic               busy;

  modport master (
    input  req_valid, req_data,
    output req_ready, tx_ready, tx_data, grant_id, busy
  );

  modport slave (
    output req_valid, req_data,
    input  req_ready, tx_ready, tx_data, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte requesters; after each
// grant it blocks further grants for a fixed frame time since uart_tx has no busy flag.
module uart_tx_sched #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FRAME_BITS = 10,
  parameter int unsigned GAP_CYC    = 2
) (
  input logic               sys_clk_50M,
  input logic               rst_n,
  uart_tx_sched_if.master   bus
);

  localparam int unsigned BIT_CYC   = CLK_FREQ / BAUD;
  localparam int unsigned FRAME_CYC = BIT_CYC * FRAME_BITS + GAP_CYC;
  localparam int unsigned CNT_W     = $clog2(FRAME_CYC);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(FRAME_CYC - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ID_W-1:0]    last_grant_q;
  logic [N_REQ-1:0]   req_ready_q;
  logic               tx_ready_q;
  logic [7:0]         tx_data_q;
  logic [ID_W-1:0]    grant_id_q;
  logic               busy_q;

  logic [ID_W-1:0]    lo_id, hi_id, win_id;
  logic [7:0]         lo_byte, hi_byte, win_byte;
  logic               hi_found;

  // Lowest valid index above the last grant wins; otherwise wrap to the lowest valid index.
  always_comb begin
    lo_id    = '0;
    hi_id    = '0;
    lo_byte  = '0;
    hi_byte  = '0;
    hi_found = 1'b0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo_id   = ID_W'(i);
        lo_byte = bus.req_data[8*i +: 8];
        if (i > int'(last_grant_q)) begin
          hi_id    = ID_W'(i);
          hi_byte  = bus.req_data[8*i +: 8];
          hi_found = 1'b1;
        end
      end
    end
    win_id   = hi_found ? hi_id : lo_id;
    win_byte = hi_found ? hi_byte : lo_byte;
  end

  always_ff @(posedge sys_clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= ID_W'(N_REQ - 1);
      req_ready_q  <= '0;
      tx_ready_q   <= 1'b0;
      tx_data_q    <= '0;
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|bus.req_valid) begin
            state_q      <= StWait;
            cnt_q        <= '0;
            last_grant_q <= win_id;
            grant_id_q   <= win_id;
            tx_data_q    <= win_byte;
            req_ready_q  <= N_REQ'(1) << win_id;
            tx_ready_q   <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        StWait: begin
          req_ready_q <= '0;
          tx_ready_q  <= 1'b0;
          if (cnt_q == CntLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.tx_ready  = tx_ready_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = busy_q;

endmodule
